// File: rtl/apb_cordic_regs_pkg.sv
// Shared definitions for the CORDIC APB register block: function codes,
// FSM states, register byte offsets and bit positions.
package apb_cordic_regs_pkg;

  typedef enum logic [2:0] {
    FUNC_SINCOS  = 3'd0,
    FUNC_INVTAN  = 3'd1,
    FUNC_VECROT  = 3'd2,
    FUNC_SVD     = 3'd3,
    FUNC_GEN_VEC = 3'd4
  } cordic_func_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } ctrl_state_e;

  localparam logic [11:0] OFF_CTRL      = 12'h000;
  localparam logic [11:0] OFF_STATUS    = 12'h004;
  localparam logic [11:0] OFF_A         = 12'h008;
  localparam logic [11:0] OFF_B         = 12'h00C;
  localparam logic [11:0] OFF_C         = 12'h010;
  localparam logic [11:0] OFF_D         = 12'h014;
  localparam logic [11:0] OFF_RES1      = 12'h018;
  localparam logic [11:0] OFF_RES2      = 12'h01C;
  localparam logic [11:0] OFF_RES3      = 12'h020;
  localparam logic [11:0] OFF_RES4      = 12'h024;
  localparam logic [11:0] OFF_RES5      = 12'h028;
  localparam logic [11:0] OFF_RES6      = 12'h02C;
  localparam logic [11:0] OFF_XYFRAC    = 12'h030;
  localparam logic [11:0] OFF_PHFRAC    = 12'h034;
  localparam logic [11:0] OFF_SCALE     = 12'h038;
  localparam logic [11:0] OFF_XYONE     = 12'h03C;
  localparam logic [11:0] OFF_INVTAN_LO = 12'h080;
  localparam logic [11:0] OFF_INVTAN_HI = 12'h0FC;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 8;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

  function automatic logic [31:0] zext5(input logic [4:0] v);
    return {27'd0, v};
  endfunction

endpackage

// File: rtl/apb_cordic_regs_if.sv
// APB3 completer-side bus bundle for the CORDIC register block.
interface apb_cordic_regs_if #(
  parameter int ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_cordic_invtan_rf.sv
// 32x32 arctan table: single write port, one indexed read port and a
// flattened view that feeds both CORDIC engines.
module apb_cordic_invtan_rf (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [4:0]    idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [1023:0] flat
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) mem_q[k] <= 32'd0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

  for (genvar g = 0; g < 32; g++) begin : g_flat
    assign flat[32*g +: 32] = mem_q[g];
  end

endmodule

// File: rtl/apb_cordic_regs.sv
// APB3 register file in front of the CORDIC control FSM: operands, config,
// arctan table, start/done handshake and a level interrupt.
module apb_cordic_regs
  import apb_cordic_regs_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] RST_XYONE  = 32'h0100_0000,
  parameter logic [4:0]  RST_XYFRAC = 5'd24,
  parameter logic [4:0]  RST_PHFRAC = 5'd29
) (
  input  logic            clk,
  input  logic            rst_n,
  apb_cordic_regs_if.slave apb,
  output logic            irq,
  output logic            cordic_start,
  output logic [2:0]      cordic_func,
  output logic [31:0]     a,
  output logic [31:0]     b,
  output logic [31:0]     c,
  output logic [31:0]     d,
  input  logic            write_op,
  input  logic [31:0]     out1,
  input  logic [31:0]     out2,
  input  logic [31:0]     out3,
  input  logic [31:0]     out4,
  input  logic [31:0]     out5,
  input  logic [31:0]     out6,
  output logic [4:0]      XYFRACBASE,
  output logic [4:0]      PHASEFRACBASE,
  output logic [31:0]     SCALE_FACTOR,
  output logic [31:0]     XYBASEONE,
  output logic [1023:0]   INVTAN
);

  ctrl_state_e state_q, state_d;
  logic [2:0]  func_q, func_d, cfunc_q, cfunc_d;
  logic        irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, start_q, start_d;
  logic [31:0] opnd_q [4];
  logic [31:0] opnd_d [4];
  logic [31:0] res_q [6];
  logic [31:0] res_d [6];
  logic [31:0] out_s [6];
  logic [4:0]  xyfrac_q, xyfrac_d, phfrac_q, phfrac_d;
  logic [31:0] scale_q, scale_d, xyone_q, xyone_d;

  logic [ADDR_W-1:0] addr_s;
  logic        access_s, hit_s, ro_s, locked_s, inv_hit_s, start_req_s, err_s, wr_ok_s;
  logic [31:0] rdata_s, inv_rdata_s;
  logic        unused_s;

  assign addr_s      = {apb.paddr[ADDR_W-1:2], 2'b00};
  assign unused_s    = ^apb.paddr[1:0];
  assign out_s       = '{out1, out2, out3, out4, out5, out6};
  assign access_s    = apb.psel & apb.penable;
  assign inv_hit_s   = (addr_s >= ADDR_W'(OFF_INVTAN_LO)) && (addr_s <= ADDR_W'(OFF_INVTAN_HI));
  assign start_req_s = access_s & apb.pwrite & (addr_s == ADDR_W'(OFF_CTRL)) & apb.pwdata[CTRL_START_BIT];

  // Address decode: hit/attribute flags and the read value of the addressed register
  always_comb begin
    hit_s    = 1'b0;
    ro_s     = 1'b0;
    locked_s = 1'b0;
    rdata_s  = 32'd0;
    if (inv_hit_s) begin
      hit_s    = 1'b1;
      locked_s = 1'b1;
      rdata_s  = inv_rdata_s;
    end else begin
      case (addr_s)
        ADDR_W'(OFF_CTRL):   begin hit_s = 1'b1; rdata_s = {23'd0, irq_en_q, 1'b0, func_q, 4'd0}; end
        ADDR_W'(OFF_STATUS): begin
          hit_s                  = 1'b1;
          rdata_s[STAT_BUSY_BIT] = (state_q == S_BUSY);
          rdata_s[STAT_DONE_BIT] = done_q;
          rdata_s[STAT_ERR_BIT]  = err_q;
        end
        ADDR_W'(OFF_A):      begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = opnd_q[0]; end
        ADDR_W'(OFF_B):      begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = opnd_q[1]; end
        ADDR_W'(OFF_C):      begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = opnd_q[2]; end
        ADDR_W'(OFF_D):      begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = opnd_q[3]; end
        ADDR_W'(OFF_RES1):   begin hit_s = 1'b1; ro_s = 1'b1; rdata_s = res_q[0]; end
        ADDR_W'(OFF_RES2):   begin hit_s = 1'b1; ro_s = 1'b1; rdata_s = res_q[1]; end
        ADDR_W'(OFF_RES3):   begin hit_s = 1'b1; ro_s = 1'b1; rdata_s = res_q[2]; end
        ADDR_W'(OFF_RES4):   begin hit_s = 1'b1; ro_s = 1'b1; rdata_s = res_q[3]; end
        ADDR_W'(OFF_RES5):   begin hit_s = 1'b1; ro_s = 1'b1; rdata_s = res_q[4]; end
        ADDR_W'(OFF_RES6):   begin hit_s = 1'b1; ro_s = 1'b1; rdata_s = res_q[5]; end
        ADDR_W'(OFF_XYFRAC): begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = zext5(xyfrac_q); end
        ADDR_W'(OFF_PHFRAC): begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = zext5(phfrac_q); end
        ADDR_W'(OFF_SCALE):  begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = scale_q; end
        ADDR_W'(OFF_XYONE):  begin hit_s = 1'b1; locked_s = 1'b1; rdata_s = xyone_q; end
        default:             hit_s = 1'b0;
      endcase
    end
  end

  // Errored writes (unmapped, read-only, locked while busy, restart while busy) commit nothing
  assign err_s = access_s & (~hit_s | (apb.pwrite & ro_s) |
                             (apb.pwrite & locked_s & (state_q == S_BUSY)) |
                             (start_req_s & (state_q == S_BUSY)));
  assign wr_ok_s = access_s & apb.pwrite & ~err_s;

  assign apb.prdata  = (!apb.pwrite && hit_s) ? rdata_s : 32'd0;
  assign apb.pslverr = err_s;
  assign apb.pready  = 1'b1;

  // Next-state: register writes, start/done handshake; result capture and flag sets win over W1C
  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    irq_en_d = irq_en_q;
    cfunc_d  = cfunc_q;
    done_d   = done_q;
    err_d    = err_q;
    start_d  = 1'b0;
    opnd_d   = opnd_q;
    res_d    = res_q;
    xyfrac_d = xyfrac_q;
    phfrac_d = phfrac_q;
    scale_d  = scale_q;
    xyone_d  = xyone_q;
    if (wr_ok_s && !inv_hit_s) begin
      case (addr_s)
        ADDR_W'(OFF_CTRL): begin
          func_d   = apb.pwdata[6:4];
          irq_en_d = apb.pwdata[CTRL_IRQ_EN_BIT];
          if (apb.pwdata[CTRL_START_BIT]) begin
            state_d = S_BUSY;
            start_d = 1'b1;
            cfunc_d = apb.pwdata[6:4];
          end
        end
        ADDR_W'(OFF_STATUS): begin
          if (apb.pwdata[STAT_DONE_BIT]) done_d = 1'b0;
          if (apb.pwdata[STAT_ERR_BIT])  err_d  = 1'b0;
        end
        ADDR_W'(OFF_A):      opnd_d[0] = apb.pwdata;
        ADDR_W'(OFF_B):      opnd_d[1] = apb.pwdata;
        ADDR_W'(OFF_C):      opnd_d[2] = apb.pwdata;
        ADDR_W'(OFF_D):      opnd_d[3] = apb.pwdata;
        ADDR_W'(OFF_XYFRAC): xyfrac_d  = apb.pwdata[4:0];
        ADDR_W'(OFF_PHFRAC): phfrac_d  = apb.pwdata[4:0];
        ADDR_W'(OFF_SCALE):  scale_d   = apb.pwdata;
        ADDR_W'(OFF_XYONE):  xyone_d   = apb.pwdata;
        default:             start_d   = 1'b0;
      endcase
    end
    if (start_req_s && state_q == S_BUSY) err_d = 1'b1;
    if (state_q == S_BUSY && write_op) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      res_d   = out_s;
    end
  end

  // State and register flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      func_q   <= 3'd0;
      irq_en_q <= 1'b0;
      cfunc_q  <= 3'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      for (int k = 0; k < 4; k++) opnd_q[k] <= 32'd0;
      for (int k = 0; k < 6; k++) res_q[k]  <= 32'd0;
      xyfrac_q <= RST_XYFRAC;
      phfrac_q <= RST_PHFRAC;
      scale_q  <= 32'd0;
      xyone_q  <= RST_XYONE;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      irq_en_q <= irq_en_d;
      cfunc_q  <= cfunc_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      opnd_q   <= opnd_d;
      res_q    <= res_d;
      xyfrac_q <= xyfrac_d;
      phfrac_q <= phfrac_d;
      scale_q  <= scale_d;
      xyone_q  <= xyone_d;
    end
  end

  apb_cordic_invtan_rf u_invtan (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok_s & inv_hit_s),
    .idx   (addr_s[6:2]),
    .wdata (apb.pwdata),
    .rdata (inv_rdata_s),
    .flat  (INVTAN)
  );

  assign irq           = done_q & irq_en_q;
  assign cordic_start  = start_q;
  assign cordic_func   = cfunc_q;
  assign a             = opnd_q[0];
  assign b             = opnd_q[1];
  assign c             = opnd_q[2];
  assign d             = opnd_q[3];
  assign XYFRACBASE    = xyfrac_q;
  assign PHASEFRACBASE = phfrac_q;
  assign SCALE_FACTOR  = scale_q;
  assign XYBASEONE     = xyone_q;

endmodule

// File: tb/tb_apb_cordic_regs.sv
// Scoreboard bench for apb_cordic_regs: directed scenarios then random APB
// traffic and result strobes, checked against a word-array register model.
module tb_apb_cordic_regs;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            irq, cordic_start, write_op = 1'b0;
  logic [2:0]      cordic_func;
  logic [31:0]     a, b, c, d, SCALE_FACTOR, XYBASEONE;
  logic [31:0]     out_v [6];
  logic [4:0]      XYFRACBASE, PHASEFRACBASE;
  logic [1023:0]   INVTAN;

  apb_cordic_regs_if #(.ADDR_W(12)) apb_if ();

  apb_cordic_regs dut (
    .clk(clk), .rst_n(rst_n), .apb(apb_if), .irq(irq),
    .cordic_start(cordic_start), .cordic_func(cordic_func),
    .a(a), .b(b), .c(c), .d(d), .write_op(write_op),
    .out1(out_v[0]), .out2(out_v[1]), .out3(out_v[2]),
    .out4(out_v[3]), .out5(out_v[4]), .out6(out_v[5]),
    .XYFRACBASE(XYFRACBASE), .PHASEFRACBASE(PHASEFRACBASE),
    .SCALE_FACTOR(SCALE_FACTOR), .XYBASEONE(XYBASEONE), .INVTAN(INVTAN)
  );

  always #5 clk = ~clk;

  typedef struct { bit [31:0] rd; bit err; } exp_t;
  exp_t exp_q[$];
  int   start_exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: one 32-bit word per aligned byte offset 0x00..0xFC
  bit [31:0] m_reg [64];
  bit        m_busy, m_done, m_err, m_irq_en;
  bit [2:0]  m_func, m_cfunc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 64; k++) m_reg[k] = 32'd0;
    m_reg[12] = 32'd24;
    m_reg[13] = 32'd29;
    m_reg[15] = 32'h0100_0000;
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_irq_en = 1'b0;
    m_func = 3'd0; m_cfunc = 3'd0;
    start_exp_q.delete();
  endfunction

  function automatic bit m_mapped(input int ad);
    return ad == 0 || ad == 4 || (ad >= 8 && ad <= 60) || (ad >= 128 && ad <= 252);
  endfunction
  function automatic bit m_ro(input int ad);
    return ad >= 24 && ad <= 44;
  endfunction
  function automatic bit m_locked(input int ad);
    return (ad >= 8 && ad <= 20) || (ad >= 48 && ad <= 60) || (ad >= 128 && ad <= 252);
  endfunction
  function automatic bit [31:0] m_read(input int ad);
    if (ad == 0) return (32'(m_irq_en) << 8) | (32'(m_func) << 4);
    if (ad == 4) return 32'(m_busy) | (32'(m_done) << 1) | (32'(m_err) << 2);
    return m_reg[ad / 4];
  endfunction

  function automatic void m_result();
    if (m_busy) begin
      for (int k = 0; k < 6; k++) m_reg[6 + k] = out_v[k];
      m_done = 1'b1;
      m_busy = 1'b0;
    end
  endfunction

  task automatic new_outs();
    for (int k = 0; k < 6; k++) out_v[k] = $urandom;
  endtask

  // One APB transfer, entered and left just after a rising edge; optional write_op in the access cycle
  task automatic apb(input bit wr, input int addr, input bit [31:0] data, input bit wop);
    int   ad;
    bit   err, busy_pre;
    exp_t e;
    ad = addr & 32'hFFC;
    busy_pre = m_busy;
    err = !m_mapped(ad) || (wr && m_ro(ad)) || (wr && m_busy && m_locked(ad)) ||
          (wr && ad == 0 && data[0] && m_busy);
    e.rd  = (!wr && m_mapped(ad)) ? m_read(ad) : 32'd0;
    e.err = err;
    exp_q.push_back(e);
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = wr;
    apb_if.paddr = addr[11:0]; apb_if.pwdata = data;
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    if (wop) write_op = 1'b1;
    @(posedge clk);
    if (wr && !err) begin
      if (ad == 0) begin
        m_func = data[6:4]; m_irq_en = data[8];
        if (data[0]) begin
          m_busy = 1'b1; m_cfunc = data[6:4];
          start_exp_q.push_back(int'(data[6:4]));
        end
      end else if (ad == 4) begin
        if (data[1]) m_done = 1'b0;
        if (data[2]) m_err = 1'b0;
      end else begin
        m_reg[ad / 4] = (ad == 48 || ad == 52) ? (data & 32'h1F) : data;
      end
    end
    if (wr && ad == 0 && data[0] && busy_pre) m_err = 1'b1;
    if (wop && busy_pre) m_result();
    #1;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; write_op = 1'b0;
  endtask

  task automatic wop_pulse();
    write_op = 1'b1;
    @(posedge clk);
    m_result();
    #1 write_op = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops scoreboard entries on each access phase, checks start pulses and irq level
  always @(negedge clk) begin
    if (apb_if.psel && apb_if.penable) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL apb_unexpected access at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("prdata", apb_if.prdata, e.rd);
        chk("pslverr", 32'(apb_if.pslverr), 32'(e.err));
        chk("pready", 32'(apb_if.pready), 32'd1);
      end
    end
    if (cordic_start) begin
      if (start_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL start_pulse actual=1 expected=0 at %0t", $time);
      end else begin
        chk("start_func", 32'(cordic_func), 32'(start_exp_q.pop_front()));
      end
    end
    chk("irq", 32'(irq), 32'(m_done & m_irq_en));
  end

  initial begin
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = 12'd0; apb_if.pwdata = 32'd0;
    new_outs();
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_xyone_port", XYBASEONE, 32'h0100_0000);
    chk("rst_cordic_func", 32'(cordic_func), 32'd0);

    // 1: reset values and basic read-back
    apb(0, 12'h004, 32'd0, 0);
    apb(0, 12'h03C, 32'd0, 0);
    apb(0, 12'h030, 32'd0, 0);
    apb(1, 12'h094, 32'h0C90_FDAA, 0);
    apb(1, 12'h008, 32'h1234_5678, 0);
    apb(0, 12'h094, 32'd0, 0);
    apb(0, 12'h008, 32'd0, 0);
    apb(1, 12'h030, 32'hFFFF_FFE7, 0);
    apb(0, 12'h030, 32'd0, 0);

    // 2: start, result capture, irq, W1C of DONE
    apb(1, 12'h000, 32'h101, 0);
    apb(0, 12'h004, 32'd0, 0);
    new_outs(); out_v[0] = 32'hAAAA_0001;
    wop_pulse();
    apb(0, 12'h018, 32'd0, 0);
    apb(0, 12'h02C, 32'd0, 0);
    apb(0, 12'h004, 32'd0, 0);
    apb(1, 12'h004, 32'h2, 0);
    apb(0, 12'h004, 32'd0, 0);

    // 3: locked writes and restart while busy
    apb(1, 12'h000, 32'h131, 0);
    apb(1, 12'h008, 32'h1, 0);
    apb(1, 12'h03C, 32'h5, 0);
    apb(1, 12'h018, 32'h5, 0);
    apb(1, 12'h000, 32'h121, 0);
    chk("func_svd_kept", 32'(cordic_func), 32'h3);
    apb(0, 12'h008, 32'd0, 0);
    apb(0, 12'h000, 32'd0, 0);
    apb(0, 12'h004, 32'd0, 0);
    new_outs(); wop_pulse();
    apb(1, 12'h004, 32'h6, 0);

    // 4: result strobe while idle is ignored
    new_outs(); wop_pulse();
    apb(0, 12'h018, 32'd0, 0);
    apb(0, 12'h004, 32'd0, 0);

    // 5: set beats W1C in the same cycle; unmapped read
    apb(1, 12'h000, 32'h141, 0);
    new_outs();
    apb(1, 12'h004, 32'h2, 1);
    apb(0, 12'h004, 32'd0, 0);
    apb(0, 12'h1F0, 32'd0, 0);
    apb(0, 12'h040, 32'd0, 0);

    // 6: reset mid-busy, late strobe ignored, restart works
    apb(1, 12'h000, 32'h121, 0);
    @(posedge clk); #1;
    do_reset();
    apb(0, 12'h004, 32'd0, 0);
    new_outs(); wop_pulse();
    apb(0, 12'h018, 32'd0, 0);
    apb(0, 12'h004, 32'd0, 0);
    apb(1, 12'h000, 32'h121, 0);
    new_outs(); wop_pulse();
    apb(0, 12'h01C, 32'd0, 0);
    apb(0, 12'h004, 32'd0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int sel, ad;
      sel = $urandom_range(0, 9);
      ad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 63) * 4;
      if (sel <= 3) apb(0, ad, 32'd0, 0);
      else if (sel <= 7) apb(1, ad, $urandom, 0);
      else if (sel == 8) begin new_outs(); wop_pulse(); end
      else begin new_outs(); apb(1, 12'h004, $urandom, 1); end
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 32; k++) chk("invtan_port", INVTAN[32*k +: 32], m_reg[32 + k]);
    chk("a_port", a, m_reg[2]);
    chk("b_port", b, m_reg[3]);
    chk("c_port", c, m_reg[4]);
    chk("d_port", d, m_reg[5]);
    chk("xyfrac_port", 32'(XYFRACBASE), m_reg[12]);
    chk("phfrac_port", 32'(PHASEFRACBASE), m_reg[13]);
    chk("scale_port", SCALE_FACTOR, m_reg[14]);
    chk("xyone_port", XYBASEONE, m_reg[15]);
    chk("cfunc_port", 32'(cordic_func), 32'(m_cfunc));
    chk("start_pending", 32'(start_exp_q.size()), 32'd0);
    chk("apb_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
